// File: rtl/seg_scan_mux_pkg.sv
// Shared definitions for seg_scan_mux: scan FSM states, 7-segment patterns
// ({g,f,e,d,c,b,a}, 1 = on) and the BCD pattern lookup.
package seg_scan_mux_pkg;

    typedef enum logic {
        ST_SHOW,
        ST_GAP
    } scan_state_e;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Non-decimal codes 10..15 show nothing.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        case (code)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_mux_bcd7seg_dec.sv
// Combinational BCD code to 7-segment decoder with a blank override;
// one instance is shared by all scanned digits.
module bcd7seg_dec
    import seg_scan_mux_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = blank_i ? SEG_OFF : bcd_to_seg(code_i);
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed N-digit 7-segment scanner with dead-time and frame-aligned
// double buffering. Define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned DIV       = 50000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  bi_n,
    input  logic                  lt_n,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     digit_sel_n,
    output logic [SEL_W-1:0]      digit_idx,
    output logic                  frame_tick
);

    localparam int unsigned       CW       = $clog2(DIV + BLANK_CYC + 1);
    localparam logic [CW-1:0]     DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]     GAP_LAST = CW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
    localparam logic [SEL_W-1:0]  IDX_LAST = SEL_W'(DIGITS - 1);

    scan_state_e               state_q;
    logic [CW-1:0]             presc_q;
    logic [SEL_W-1:0]          idx_q;
    logic                      wrap_q;
    logic [4*DIGITS-1:0]       pend_bcd_q;
    logic [4*DIGITS-1:0]       act_bcd_q;
    logic [DIGITS-1:0]         pend_dp_q;
    logic [DIGITS-1:0]         act_dp_q;

    logic                      slot_end;
    logic                      advance;
    logic                      wrap;
    logic [SEL_W-1:0]          idx_d;
    logic [3:0]                cur_code;
    logic                      cur_dp;
    logic                      lzb_blank;
    logic [6:0]                dec_seg;
    logic [DIGITS-1:0]         sel_onehot;

    always_comb begin
        slot_end = (state_q == ST_SHOW) ? (presc_q == DIV_LAST) : (presc_q == GAP_LAST);
        advance  = slot_end && ((state_q == ST_GAP) || (BLANK_CYC == 0));
        wrap     = advance && (idx_q == IDX_LAST);
        idx_d    = wrap ? '0 : idx_q + 1'b1;
    end

    always_comb begin
        cur_code = '0;
        cur_dp   = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == SEL_W'(k)) begin
                cur_code = act_bcd_q[4*k +: 4];
                cur_dp   = act_dp_q[k];
            end
        end
        sel_onehot = DIGITS'(1) << idx_q;
    end

`ifdef SEG_LZB_EN
    // Walk from the most significant digit down; blank while every digit so far is zero.
    logic lead_zero;
    always_comb begin
        lead_zero = 1'b1;
        lzb_blank = 1'b0;
        for (int unsigned k = DIGITS; k > 0; k--) begin
            lead_zero = lead_zero && (act_bcd_q[4*(k-1) +: 4] == 4'd0);
            if ((idx_q == SEL_W'(k - 1)) && (k > 1)) begin
                lzb_blank = lead_zero;
            end
        end
    end
`else
    assign lzb_blank = 1'b0;
`endif

    bcd7seg_dec u_dec (
        .code_i  (cur_code),
        .blank_i (lzb_blank),
        .seg_o   (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SHOW;
            presc_q     <= '0;
            idx_q       <= '0;
            wrap_q      <= 1'b0;
            pend_bcd_q  <= '0;
            pend_dp_q   <= '0;
            act_bcd_q   <= '0;
            act_dp_q    <= '0;
            seg         <= '0;
            digit_sel_n <= '1;
            digit_idx   <= '0;
            frame_tick  <= 1'b0;
        end else begin
            // Output stage: pins follow the internal scan state one cycle later.
            digit_idx  <= idx_q;
            frame_tick <= wrap_q;
            if (!lt_n) begin
                seg <= '1;
            end else if (!bi_n || (state_q == ST_GAP)) begin
                seg <= '0;
            end else begin
                seg <= {cur_dp, dec_seg};
            end
            if (!bi_n || (state_q == ST_GAP)) begin
                digit_sel_n <= '1;
            end else begin
                digit_sel_n <= ~sel_onehot;
            end

            case (state_q)
                ST_SHOW: begin
                    if (slot_end) begin
                        presc_q <= '0;
                        if (BLANK_CYC != 0) begin
                            state_q <= ST_GAP;
                        end
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (slot_end) begin
                        presc_q <= '0;
                        state_q <= ST_SHOW;
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_SHOW;
                    presc_q <= '0;
                end
            endcase

            if (advance) begin
                idx_q <= idx_d;
            end
            wrap_q <= wrap;

            if (load) begin
                pend_bcd_q <= bcd_in;
                pend_dp_q  <= dp_in;
            end
            // A load on the wrap edge bypasses the pending buffer.
            if (wrap) begin
                act_bcd_q <= load ? bcd_in : pend_bcd_q;
                act_dp_q  <= load ? dp_in  : pend_dp_q;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux (DIGITS=4, DIV=4, BLANK_CYC=1).
// Reference model works from cycle position within the 20-cycle frame.
module tb_seg_scan_mux;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DIV    = 4;
    localparam int unsigned BLANK  = 1;
    localparam int unsigned SLOT   = DIV + BLANK;
    localparam int unsigned FRAME  = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        bi_n = 1'b1;
    logic        lt_n = 1'b1;
    logic [7:0]  seg;
    logic [3:0]  digit_sel_n;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int unsigned checks = 0;
    int unsigned fails  = 0;

    seg_scan_mux #(
        .DIGITS    (DIGITS),
        .SEL_W     (2),
        .DIV       (DIV),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .load        (load),
        .bi_n        (bi_n),
        .lt_n        (lt_n),
        .seg         (seg),
        .digit_sel_n (digit_sel_n),
        .digit_idx   (digit_idx),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference state: cycles since reset release, and the two data buffers.
    int unsigned k = 0;
    logic [15:0] m_pend_bcd = '0, m_act_bcd = '0;
    logic [3:0]  m_pend_dp = '0, m_act_dp = '0;
    logic [6:0]  pat [16];

    function automatic logic [7:0] model_seg(input int unsigned slot);
        logic [3:0] code;
        logic       blank;
        code  = m_act_bcd[slot*4 +: 4];
        blank = 1'b0;
`ifdef SEG_LZB_EN
        if (slot != 0) begin
            blank = 1'b1;
            for (int unsigned j = slot; j < DIGITS; j++)
                if (m_act_bcd[j*4 +: 4] != 4'd0) blank = 1'b0;
        end
`endif
        return {m_act_dp[slot], blank ? 7'h00 : pat[code]};
    endfunction

    task automatic step(input logic r, input logic ld, input logic [15:0] b,
                        input logic [3:0] d, input logic bi, input logic lt);
        logic [7:0]  e_seg;
        logic [3:0]  e_sel;
        logic [1:0]  e_idx;
        logic        e_tick;
        int unsigned p, slot;
        logic        lit;
        rst = r; load = ld; bcd_in = b; dp_in = d; bi_n = bi; lt_n = lt;
        @(posedge clk);
        if (r) begin
            k = 0;
            m_pend_bcd = '0; m_act_bcd = '0; m_pend_dp = '0; m_act_dp = '0;
            e_seg = 8'h00; e_sel = 4'hF; e_idx = 2'd0; e_tick = 1'b0;
        end else begin
            p     = k % FRAME;
            slot  = p / SLOT;
            lit   = (p % SLOT) < DIV;
            e_idx = 2'(slot);
            e_tick = (k > 0) && (p == 0);
            e_sel = (!bi || !lit) ? 4'hF : ~(4'b0001 << slot);
            if (!lt)              e_seg = 8'hFF;
            else if (!bi || !lit) e_seg = 8'h00;
            else                  e_seg = model_seg(slot);
            k++;
            if (k % FRAME == 0) begin
                m_act_bcd = ld ? b : m_pend_bcd;
                m_act_dp  = ld ? d : m_pend_dp;
            end
            if (ld) begin
                m_pend_bcd = b;
                m_pend_dp  = d;
            end
        end
        #1;
        checks++;
        assert (seg === e_seg) else begin
            fails++; $error("FAIL seg k=%0d observed=%h expected=%h", k, seg, e_seg);
        end
        checks++;
        assert (digit_sel_n === e_sel) else begin
            fails++; $error("FAIL digit_sel_n k=%0d observed=%b expected=%b", k, digit_sel_n, e_sel);
        end
        checks++;
        assert (digit_idx === e_idx) else begin
            fails++; $error("FAIL digit_idx k=%0d observed=%0d expected=%0d", k, digit_idx, e_idx);
        end
        checks++;
        assert (frame_tick === e_tick) else begin
            fails++; $error("FAIL frame_tick k=%0d observed=%b expected=%b", k, frame_tick, e_tick);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b1);
    endtask

    task automatic seek(input int unsigned pos);
        for (int unsigned i = 0; i < FRAME && (k % FRAME) != pos; i++) idle(1);
    endtask

    initial begin
        pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F;
        pat[4] = 7'h66; pat[5] = 7'h6D; pat[6] = 7'h7D; pat[7] = 7'h07;
        pat[8] = 7'h7F; pat[9] = 7'h6F;
        for (int unsigned i = 10; i < 16; i++) pat[i] = 7'h00;

        // Reset held three cycles, then release.
        for (int unsigned i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0, 1'b1, 1'b1);
        idle(1);
        checks++;
        assert (digit_sel_n === 4'b1110) else begin
            fails++; $error("FAIL release_sel observed=%b expected=1110", digit_sel_n);
        end

        // Free run over two full frames.
        idle(2 * FRAME);

        // Mid-frame load: old data until the wrap, then 1234.
        seek(7);
        step(1'b0, 1'b1, 16'h1234, 4'h0, 1'b1, 1'b1);
        idle(FRAME + 5);

        // Load exactly on the frame boundary: goes straight to active.
        seek(FRAME - 1);
        step(1'b0, 1'b1, 16'h0042, 4'h0, 1'b1, 1'b1);
        idle(FRAME);

        // Back-to-back loads, last wins; code A with dp.
        step(1'b0, 1'b1, 16'h5678, 4'hF, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h0A0A, 4'h1, 1'b1, 1'b1);
        idle(2 * FRAME);

        // All-zero word (leading-zero boundary case).
        step(1'b0, 1'b1, 16'h0000, 4'h0, 1'b1, 1'b1);
        idle(2 * FRAME);

        // Lamp test, then blanking, then lamp test over blanking.
        for (int unsigned i = 0; i < FRAME; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0);
        for (int unsigned i = 0; i < FRAME; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
        for (int unsigned i = 0; i < 5; i++)     step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);

        // Reset mid-slot on digit 2 with data loaded.
        step(1'b0, 1'b1, 16'h9876, 4'h3, 1'b1, 1'b1);
        idle(FRAME);
        seek(2 * SLOT + 1);
        step(1'b1, 1'b0, 16'h0, 4'h0, 1'b1, 1'b1);
        idle(FRAME + 3);

        // Randomized traffic.
        for (int unsigned i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 15) == 0),
                 16'($urandom),
                 4'($urandom),
                 ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 29) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
